opb_fifo_simulink2ppc: RTL and testbench

//  OPB slave that carries data from the Simulink fabric to the PPC, the opposite

---
 rtl/opb_fifo_simulink2ppc.sv | 139 +++++++++++++
 tb/tb_opb_fifo_simulink2ppc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_fifo_simulink2ppc.sv
// OPB slave exposing a fabric-fed word FIFO to the PPC: DATA pops, STATUS reports
// count/overflow/empty, CTRL flushes or clears overflow. Single clock, sync reset.
module opb_fifo_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR        = 32'h01000900,
    parameter logic [31:0] C_HIGHADDR        = 32'h010009FF,
    parameter int          C_OPB_AWIDTH      = 32,
    parameter int          C_OPB_DWIDTH      = 32,
    parameter string       C_FAMILY          = "virtex5",
    parameter int          C_FIFO_DEPTH_LOG2 = 4
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic                      Sl_xferAck,
    input  logic [31:0]               user_data_in,
    input  logic                      user_valid
);

    localparam int DEPTH = 1 << C_FIFO_DEPTH_LOG2;
    localparam int PW    = C_FIFO_DEPTH_LOG2;
    localparam int CW    = C_FIFO_DEPTH_LOG2 + 1;

    localparam logic [1:0] IDX_DATA   = 2'd0;
    localparam logic [1:0] IDX_STATUS = 2'd1;
    localparam logic [1:0] IDX_CTRL   = 2'd2;

    localparam bit unused_family = (C_FAMILY == "");

    logic [31:0]             mem_q [DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic                    ack_q, ack_d;
    logic [0:C_OPB_DWIDTH-1] dbus_q, dbus_d;

    logic        in_range, hit, empty, full;
    logic        pop, push_ok, ovf_set;
    logic        ctrl_wr, flush, clr_ovf;
    logic [1:0]  word_idx;
    logic [31:0] rdata;
    logic        unused_inputs;

    assign in_range = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    // The cycle after a hit carries the ack, so a held select cannot re-hit then.
    assign hit      = OPB_select && in_range && !ack_q;
    assign word_idx = OPB_ABus[C_OPB_AWIDTH-4:C_OPB_AWIDTH-3];

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // An empty FIFO never pops, so a same-cycle push cannot bypass to the reader.
    assign pop     = hit && OPB_RNW && (word_idx == IDX_DATA) && !empty;
    assign ctrl_wr = hit && !OPB_RNW && (word_idx == IDX_CTRL) && OPB_BE[3];
    assign flush   = ctrl_wr && OPB_DBus[C_OPB_DWIDTH-1];
    assign clr_ovf = ctrl_wr && OPB_DBus[C_OPB_DWIDTH-2];

    // A flush discards the concurrent push without flagging it as overflow.
    assign push_ok = user_valid && !flush && (!full || pop);
    assign ovf_set = user_valid && !flush && full && !pop;

    always_comb begin
        rdata = '0;
        case (word_idx)
            IDX_DATA:   if (!empty) rdata = mem_q[rd_ptr_q];
            IDX_STATUS: rdata = {{(16-CW){1'b0}}, count_q, 14'd0, ovf_q, empty};
            default:    rdata = '0;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        ack_d    = hit;
        dbus_d   = (hit && OPB_RNW) ? rdata : '0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        if (ovf_set)      ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ack_q    <= 1'b0;
            dbus_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ack_q    <= ack_d;
            dbus_q   <= dbus_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define validity.
    always_ff @(posedge OPB_Clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= user_data_in;
    end

    assign Sl_DBus    = dbus_q;
    assign Sl_xferAck = ack_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    assign unused_inputs = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:C_OPB_DWIDTH-3]};

endmodule

// File: tb/tb_opb_fifo_simulink2ppc.sv
// Bench for opb_fifo_simulink2ppc: directed scenarios plus random traffic, compared
// every cycle against a queue-based model of the FIFO and register map.
module tb_opb_fifo_simulink2ppc;

    localparam logic [31:0] BASE = 32'h01000900;
    localparam logic [31:0] HIGH = 32'h010009FF;
    localparam int          DEPTH = 16;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic        Sl_xferAck;
    logic [31:0] user_data_in;
    logic        user_valid;

    opb_fifo_simulink2ppc dut (
        .OPB_Clk      (OPB_Clk),
        .OPB_Rst      (OPB_Rst),
        .OPB_ABus     (OPB_ABus),
        .OPB_BE       (OPB_BE),
        .OPB_DBus     (OPB_DBus),
        .OPB_RNW      (OPB_RNW),
        .OPB_select   (OPB_select),
        .OPB_seqAddr  (OPB_seqAddr),
        .Sl_DBus      (Sl_DBus),
        .Sl_errAck    (Sl_errAck),
        .Sl_retry     (Sl_retry),
        .Sl_toutSup   (Sl_toutSup),
        .Sl_xferAck   (Sl_xferAck),
        .user_data_in (user_data_in),
        .user_valid   (user_valid)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: word queue, sticky overflow, and whether an ack is pending.
    logic [31:0] q[$];
    bit          m_ovf = 1'b0;
    bit          m_ack = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One bus clock: drive inputs, predict, let the edge pass, compare the outputs.
    task automatic cycle(input logic sel, input logic [31:0] addr, input logic rnw,
                         input logic [3:0] be, input logic [31:0] wdata,
                         input logic uv, input logic [31:0] ud, input logic rst);
        bit          hit, pop, full, flush, clr, set;
        int          n;
        logic [1:0]  idx;
        logic [31:0] exp;
        OPB_Rst      = rst;
        OPB_select   = sel;
        OPB_ABus     = addr;
        OPB_RNW      = rnw;
        OPB_BE       = be;
        OPB_DBus     = wdata;
        OPB_seqAddr  = 1'($urandom_range(0, 1));
        user_valid   = uv;
        user_data_in = ud;

        n    = q.size();
        idx  = addr[3:2];
        hit  = !rst && sel && addr >= BASE && addr <= HIGH && !m_ack;
        exp  = 32'd0;
        if (hit && rnw && idx == 2'd0 && n > 0) exp = q[0];
        if (hit && rnw && idx == 2'd1)
            exp = (32'(n) << 16) | (m_ovf ? 32'd2 : 32'd0) | (n == 0 ? 32'd1 : 32'd0);

        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            full  = (n == DEPTH);
            pop   = hit && rnw && idx == 2'd0 && n > 0;
            flush = hit && !rnw && idx == 2'd2 && be[0] && wdata[0];
            clr   = hit && !rnw && idx == 2'd2 && be[0] && wdata[1];
            set   = 1'b0;
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (uv) begin
                    if (!full || pop) q.push_back(ud);
                    else set = 1'b1;
                end
            end
            if (clr) m_ovf = 1'b0;
            if (set) m_ovf = 1'b1;
        end
        m_ack = hit;

        @(posedge OPB_Clk);
        @(negedge OPB_Clk);
        check("ack", {31'd0, Sl_xferAck}, {31'd0, m_ack});
        check("dbus", Sl_DBus, hit ? exp : 32'd0);
    endtask

    task automatic idle();
        cycle(1'b0, 32'd0, 1'b1, 4'h0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic push(input logic [31:0] w);
        cycle(1'b0, 32'd0, 1'b1, 4'h0, 32'd0, 1'b1, w, 1'b0);
    endtask

    task automatic rd(input logic [3:0] off, input logic [31:0] expv, input string tag);
        cycle(1'b1, BASE + 32'(off), 1'b1, 4'hF, 32'd0, 1'b0, 32'd0, 1'b0);
        check(tag, Sl_DBus, expv);
        idle();
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] data, input logic [3:0] be);
        cycle(1'b1, BASE + 32'(off), 1'b0, be, data, 1'b0, 32'd0, 1'b0);
        idle();
    endtask

    initial begin
        // Reset state
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b1, 4'h0, 32'd0, 1'b0, 32'd0, 1'b1);
        check("const_outs", {29'd0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'd0);
        idle();

        // Ack latency of exactly one cycle, STATUS after reset
        cycle(1'b1, BASE + 32'h4, 1'b1, 4'hF, 32'd0, 1'b0, 32'd0, 1'b0);
        check("ack_latency", {31'd0, Sl_xferAck}, 32'd1);
        check("status_reset", Sl_DBus, 32'h00000001);
        idle();
        check("ack_drop", {31'd0, Sl_xferAck}, 32'd0);

        // Basic push/pop ordering and empty read
        for (int i = 1; i <= 3; i++) push(32'hA5A50000 + 32'(i));
        rd(4'h0, 32'hA5A50001, "pop1");
        rd(4'h0, 32'hA5A50002, "pop2");
        rd(4'h0, 32'hA5A50003, "pop3");
        rd(4'h0, 32'h00000000, "pop_empty");
        rd(4'h4, 32'h00000001, "status_empty");
        rd(4'h8, 32'h00000000, "ctrl_read");
        rd(4'hC, 32'h00000000, "reserved_read");

        // Empty FIFO: push alongside a DATA read does not bypass
        cycle(1'b1, BASE, 1'b1, 4'hF, 32'd0, 1'b1, 32'hBEEF0001, 1'b0);
        check("no_bypass", Sl_DBus, 32'h00000000);
        idle();
        rd(4'h4, 32'h00010000, "status_one");
        rd(4'h0, 32'hBEEF0001, "bypass_word");

        // Overflow: 17 pushes, then clear with BE[3] only
        for (int i = 0; i < 17; i++) push(32'h10000000 + 32'(i));
        rd(4'h4, 32'h00100002, "status_ovf");
        wr(4'h8, 32'h00000002, 4'b0001);
        rd(4'h4, 32'h00100000, "status_ovf_clr");

        // Full: push with a simultaneous pop keeps count and sets no overflow
        cycle(1'b1, BASE, 1'b1, 4'hF, 32'd0, 1'b1, 32'hDEAD0016, 1'b0);
        check("full_pushpop", Sl_DBus, 32'h10000000);
        idle();
        rd(4'h4, 32'h00100000, "status_full_pp");
        for (int i = 0; i < 16; i++)
            rd(4'h0, (i < 15) ? 32'h10000001 + 32'(i) : 32'hDEAD0016, "drain");
        rd(4'h4, 32'h00000001, "status_drained");

        // Clear-overflow write colliding with a new overflow: set wins
        for (int i = 0; i < 16; i++) push($urandom);
        cycle(1'b1, BASE + 32'h8, 1'b0, 4'b0001, 32'h2, 1'b1, 32'h0BAD0BAD, 1'b0);
        idle();
        rd(4'h4, 32'h00100002, "ovf_set_wins");

        // Flush colliding with a push: flush wins, overflow untouched
        cycle(1'b1, BASE + 32'h8, 1'b0, 4'b0001, 32'h1, 1'b1, 32'h12345678, 1'b0);
        idle();
        rd(4'h4, 32'h00000003, "flush_push");
        wr(4'h8, 32'h00000002, 4'b1110);
        rd(4'h4, 32'h00000003, "ctrl_be3_off");
        wr(4'h8, 32'h00000003, 4'b0001);
        rd(4'h4, 32'h00000001, "flush_clear");

        // Reset asserted during an ack cycle
        for (int i = 0; i < 3; i++) push(32'h77770000 + 32'(i));
        cycle(1'b1, BASE + 32'h4, 1'b1, 4'hF, 32'd0, 1'b0, 32'd0, 1'b0);
        check("pre_rst_ack", {31'd0, Sl_xferAck}, 32'd1);
        cycle(1'b0, 32'd0, 1'b1, 4'h0, 32'd0, 1'b0, 32'd0, 1'b1);
        check("rst_ack_drop", {31'd0, Sl_xferAck}, 32'd0);
        idle();
        rd(4'h4, 32'h00000001, "rst_empty");

        // Select held three cycles
        cycle(1'b1, BASE + 32'h4, 1'b1, 4'hF, 32'd0, 1'b0, 32'd0, 1'b0);
        check("held_c2", {31'd0, Sl_xferAck}, 32'd1);
        cycle(1'b1, BASE + 32'h4, 1'b1, 4'hF, 32'd0, 1'b0, 32'd0, 1'b0);
        check("held_c3", {31'd0, Sl_xferAck}, 32'd0);
        cycle(1'b1, BASE + 32'h4, 1'b1, 4'hF, 32'd0, 1'b0, 32'd0, 1'b0);
        idle();

        // Out-of-range addresses
        cycle(1'b1, 32'h01000A00, 1'b1, 4'hF, 32'd0, 1'b0, 32'd0, 1'b0);
        check("above_range", {31'd0, Sl_xferAck}, 32'd0);
        cycle(1'b1, 32'h010008FC, 1'b1, 4'hF, 32'd0, 1'b0, 32'd0, 1'b0);
        check("below_range", {31'd0, Sl_xferAck}, 32'd0);
        idle();

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] a, d;
            int          k;
            k = int'($urandom_range(0, 5));
            case (k)
                4:       a = 32'h01000A00;
                5:       a = BASE - 32'd4;
                default: a = BASE + 32'(4 * k);
            endcase
            d = ($urandom & 32'hFFFF_FFFC)
              | (($urandom_range(0, 15) == 0) ? 32'd1 : 32'd0)
              | (($urandom_range(0, 3) == 0) ? 32'd2 : 32'd0);
            cycle(1'($urandom_range(0, 2) != 0), a, 1'($urandom_range(0, 1)),
                  4'($urandom), d, 1'($urandom_range(0, 9) < 6), $urandom,
                  1'($urandom_range(0, 499) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
